// File: rtl/vector_row_writer.sv
// vector_row_writer: serializes accepted words into ASCII '0'/'1' rows with space separators and a newline
module vector_row_writer #(
  parameter int FIELD_WIDTH   = 8,
  parameter int NUM_FIELDS    = 2,
  parameter int ROW_CNT_WIDTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_FIELDS*FIELD_WIDTH-1:0] in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [7:0]                        out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic                              busy,
  output logic [ROW_CNT_WIDTH-1:0]          rows
);
  localparam int W    = NUM_FIELDS * FIELD_WIDTH;
  localparam int FI_W = NUM_FIELDS > 1 ? $clog2(NUM_FIELDS) : 1;
  localparam int BI_W = FIELD_WIDTH > 1 ? $clog2(FIELD_WIDTH) : 1;
  localparam logic [FI_W-1:0] F_LAST = FI_W'(NUM_FIELDS - 1);
  localparam logic [BI_W-1:0] B_LAST = BI_W'(FIELD_WIDTH - 1);
  typedef enum logic [1:0] {IDLE, BIT, SEP, EOL} state_t;
  state_t                   state_q, state_d;
  logic [W-1:0]             shift_q, shift_d;
  logic [FI_W-1:0]          field_idx_q, field_idx_d;
  logic [BI_W-1:0]          bit_idx_q, bit_idx_d;
  logic [7:0]               out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic [ROW_CNT_WIDTH-1:0] rows_q, rows_d;
  logic                     in_xfer, out_xfer;
  assign in_ready  = (state_q == IDLE) || (state_q == EOL && out_ready);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid_q && out_ready;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign busy      = state_q != IDLE;
  assign rows      = rows_q;
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    field_idx_d = field_idx_q;
    bit_idx_d   = bit_idx_q;
    rows_d      = rows_q;
    unique case (state_q)
      IDLE: ;
      BIT: if (out_xfer) begin
        shift_d = shift_q << 1;
        if (bit_idx_q != '0) bit_idx_d = bit_idx_q - BI_W'(1);
        else state_d = field_idx_q != F_LAST ? SEP : EOL;
      end
      SEP: if (out_xfer) begin
        field_idx_d = field_idx_q + FI_W'(1);
        bit_idx_d   = B_LAST;
        state_d     = BIT;
      end
      EOL: if (out_xfer) begin
        rows_d  = rows_q + ROW_CNT_WIDTH'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (in_xfer) begin
      shift_d     = in_data;
      field_idx_d = '0;
      bit_idx_d   = B_LAST;
      state_d     = BIT;
    end
    out_valid_d = state_d != IDLE;
    out_data_d  = state_d == BIT ? (shift_d[W-1] === 1'b1 ? 8'h31 : 8'h30) :
                  state_d == SEP ? 8'h20 :
                  state_d == EOL ? 8'h0A : 8'h00;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      field_idx_q <= '0;
      bit_idx_q   <= '0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      rows_q      <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      field_idx_q <= field_idx_d;
      bit_idx_q   <= bit_idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      rows_q      <= rows_d;
    end
  end
endmodule

// File: tb/tb_vector_row_writer.sv
// tb_vector_row_writer: directed checks of row bytes, timing, backpressure, reset and counter wrap
module tb_vector_row_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic [7:0]  i0_data = '0;
  logic        v0 = 1'b0, r0, ov0, ordy0 = 1'b1, busy0;
  logic [7:0]  o0_data;
  logic [15:0] rows0;
  logic [2:0]  i1_data = '0;
  logic        v1 = 1'b0, r1, ov1, ordy1 = 1'b1, busy1;
  logic [7:0]  o1_data;
  logic [15:0] rows1;
  logic [0:0]  i2_data = '0;
  logic        v2 = 1'b0, r2, ov2, ordy2 = 1'b1, busy2;
  logic [7:0]  o2_data;
  logic [1:0]  rows2;
  int checks = 0;
  int errors = 0;
  logic [7:0] e_a5 [10] = '{8'h31, 8'h30, 8'h31, 8'h30, 8'h20, 8'h30, 8'h31, 8'h30, 8'h31, 8'h0A};
  logic [7:0] e_ff0 [20] = '{8'h31, 8'h31, 8'h31, 8'h31, 8'h20, 8'h31, 8'h31, 8'h31, 8'h31, 8'h0A,
                             8'h30, 8'h30, 8'h30, 8'h30, 8'h20, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0A};
  logic [7:0] e_3c [10] = '{8'h30, 8'h30, 8'h31, 8'h31, 8'h20, 8'h31, 8'h31, 8'h30, 8'h30, 8'h0A};
  logic [7:0] e_01 [10] = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h20, 8'h30, 8'h30, 8'h30, 8'h31, 8'h0A};
  logic [7:0] e_101 [4] = '{8'h31, 8'h30, 8'h31, 8'h0A};
  logic [1:0] e_rows [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [3:0] stall_pat = 4'b1001;
  vector_row_writer #(.FIELD_WIDTH(4), .NUM_FIELDS(2), .ROW_CNT_WIDTH(16)) dut0 (
    .clk(clk), .rst(rst), .in_data(i0_data), .in_valid(v0), .in_ready(r0),
    .out_data(o0_data), .out_valid(ov0), .out_ready(ordy0), .busy(busy0), .rows(rows0));
  vector_row_writer #(.FIELD_WIDTH(3), .NUM_FIELDS(1), .ROW_CNT_WIDTH(16)) dut1 (
    .clk(clk), .rst(rst), .in_data(i1_data), .in_valid(v1), .in_ready(r1),
    .out_data(o1_data), .out_valid(ov1), .out_ready(ordy1), .busy(busy1), .rows(rows1));
  vector_row_writer #(.FIELD_WIDTH(1), .NUM_FIELDS(1), .ROW_CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_data(i2_data), .in_valid(v2), .in_ready(r2),
    .out_data(o2_data), .out_valid(ov2), .out_ready(ordy2), .busy(busy2), .rows(rows2));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  initial begin
    int n;
    tick();
    tick();
    rst = 1'b0;
    tick();
    #1;
    chk("rst_in_ready", r0, 1);
    chk("rst_out_valid", ov0, 0);
    chk("rst_out_data", o0_data, 8'h00);
    chk("rst_rows", rows0, 0);
    chk("rst_busy", busy0, 0);
    i0_data = 8'hA5;
    v0 = 1'b1;
    tick();
    v0 = 1'b0;
    i0_data = 8'h00;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("a5_valid", ov0, 1);
      chk("a5_byte", o0_data, e_a5[i]);
      chk("a5_busy", busy0, 1);
      chk("a5_in_ready", r0, i == 9);
      tick();
    end
    #1;
    chk("a5_done_valid", ov0, 0);
    chk("a5_done_busy", busy0, 0);
    chk("a5_rows", rows0, 1);
    i0_data = 8'hFF;
    v0 = 1'b1;
    tick();
    i0_data = 8'h00;
    for (int i = 0; i < 20; i++) begin
      if (i == 19) v0 = 1'b0;
      #1;
      chk("b2b_valid", ov0, 1);
      chk("b2b_byte", o0_data, e_ff0[i]);
      chk("b2b_in_ready", r0, i == 9 || i == 19);
      if (i == 10) chk("b2b_rows_mid", rows0, 2);
      tick();
    end
    #1;
    chk("b2b_rows", rows0, 3);
    chk("b2b_idle", busy0, 0);
    i0_data = 8'h3C;
    v0 = 1'b1;
    tick();
    v0 = 1'b0;
    n = 0;
    for (int c = 0; c < 60 && n < 10; c++) begin
      ordy0 = stall_pat[3 - (c % 4)];
      #1;
      chk("stall_valid", ov0, 1);
      chk("stall_byte", o0_data, e_3c[n]);
      if (ordy0) n++;
      tick();
    end
    chk("stall_count", n, 10);
    ordy0 = 1'b1;
    #1;
    chk("stall_idle", busy0, 0);
    chk("stall_rows", rows0, 4);
    i0_data = 8'hA5;
    v0 = 1'b1;
    tick();
    v0 = 1'b0;
    repeat (5) tick();
    #1;
    chk("mid_byte6", o0_data, 8'h30);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", ov0, 0);
    chk("mid_rst_rows", rows0, 0);
    chk("mid_rst_in_ready", r0, 1);
    chk("mid_rst_busy", busy0, 0);
    i0_data = 8'h01;
    v0 = 1'b1;
    tick();
    v0 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("post_rst_valid", ov0, 1);
      chk("post_rst_byte", o0_data, e_01[i]);
      tick();
    end
    #1;
    chk("post_rst_rows", rows0, 1);
    i1_data = 3'b101;
    v1 = 1'b1;
    tick();
    v1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("nf1_valid", ov1, 1);
      chk("nf1_byte", o1_data, e_101[i]);
      tick();
    end
    #1;
    chk("nf1_idle", ov1, 0);
    chk("nf1_rows", rows1, 1);
    i2_data = 1'b1;
    v2 = 1'b1;
    tick();
    for (int r = 0; r < 5; r++) begin
      #1;
      chk("wrap_bit", o2_data, 8'h31);
      chk("wrap_bit_in_ready", r2, 0);
      tick();
      if (r == 4) v2 = 1'b0;
      #1;
      chk("wrap_eol", o2_data, 8'h0A);
      chk("wrap_eol_in_ready", r2, 1);
      tick();
      chk("wrap_rows", rows2, e_rows[r]);
    end
    #1;
    chk("wrap_idle", ov2, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vector_row_writer.md
Name: vector_row_writer

Overview:
- Synthesizable serializer that produces lines in the team's vector-file text format from logic words.
- One accepted word becomes one ASCII row: each field is written as '0'/'1' characters MSB-first, fields are separated by a single space (0x20), and the row ends with '\n' (0x0A).
- Sits between a DUT-side capture point and a byte sink (UART, trace FIFO, or sim file writer), so rows can be parsed directly by the bench drive/load readers.

Parameters:
- FIELD_WIDTH, 8, bits per field; must be >= 1.
- NUM_FIELDS, 2, fields per row; must be >= 1.
- ROW_CNT_WIDTH, 16, width of the rows-emitted counter.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  NUM_FIELDS*FIELD_WIDTH  row word; field 0 occupies the MSBs and is written first.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word this cycle.
- out_data  out  8  ASCII byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts out_data this cycle.
- busy  out  1  a row is in progress (state != IDLE).
- rows  out  ROW_CNT_WIDTH  count of completed rows.

Behaviour:
- Reset (sync, active-high):
  - state=IDLE; out_valid=0; out_data=8'h00; rows=0; busy=0.
  - Any partial row is abandoned and never resumed.
  - in_ready=1 in the first cycle after reset is released.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_data and state hold; no byte is dropped or repeated.
- States:
  - IDLE: out_valid=0. On input transfer: latch in_data into shift register, field_idx=0, bit_idx=FIELD_WIDTH-1, go to BIT.
  - BIT: out_data = 0x31 if the latched bit is 1, else 0x30. On transfer:
    - if bit_idx>0: decrement bit_idx.
    - else if field_idx<NUM_FIELDS-1: go to SEP.
    - else: go to EOL.
  - SEP: out_data=0x20. On transfer: increment field_idx, set bit_idx=FIELD_WIDTH-1, go to BIT.
  - EOL: out_data=0x0A. On transfer: rows increments and wraps modulo 2^ROW_CNT_WIDTH.
    - If an input transfer occurs in the same cycle, go to BIT with the new word.
    - Otherwise go to IDLE.
- in_ready = (state==IDLE) || (state==EOL && out_ready).
  - This path is combinational from out_ready by design; it gives zero-bubble back-to-back rows.
- out_valid, out_data and state are registered.
- Latency: a word accepted in cycle N presents its first byte in cycle N+1.
- Bytes per row = NUM_FIELDS*FIELD_WIDTH + NUM_FIELDS (NUM_FIELDS-1 spaces plus one newline).
- With out_ready held at 1 and in_valid held at 1, throughput is exactly one byte per cycle with no gaps between rows.
- NUM_FIELDS=1: SEP is never entered.
- FIELD_WIDTH=1: each field is a single character.
- in_data is sampled only at the input transfer; later changes do not affect the row in flight.
- X/Z bits in in_data are not encoded; a non-1 bit emits 0x30.

Test Plan:
- FIELD_WIDTH=4, NUM_FIELDS=2, out_ready=1, one word 8'hA5 -> first byte appears 1 cycle after accept; bytes are 31 30 31 30 20 30 31 30 31 0A over 10 cycles; rows=1; busy falls after the 0A transfer.
- Same configuration, words 8'hFF then 8'h00 with in_valid=1 continuously -> 20 consecutive bytes with no bubble; in_ready high only in the 0A cycle; rows=2.
- Word 8'h3C with out_ready toggling 1,0,0,1,... -> out_data holds during stalls; byte stream is exactly 30 30 31 31 20 31 31 30 30 0A.
- Assert rst while the 6th byte is presented -> next cycle out_valid=0, rows=0, in_ready=1; the next word 8'h01 emits a clean full row 30 30 30 30 20 30 30 30 31 0A.
- NUM_FIELDS=1, FIELD_WIDTH=3, word 3'b101 -> bytes 31 30 31 0A, with no 0x20 emitted.
- ROW_CNT_WIDTH=2, emit 5 rows -> rows sequence is 1,2,3,0,1.
